// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bcd_pkg
// Brief    : Shared types for the BCD conversion scheduler: the scheduler
//            FSM state encoding, the 4-bit BCD digit type and a power-of-ten
//            helper used for the overflow threshold.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // One BCD digit, value 0..9 in the low nibble.
  typedef logic [3:0] bcdDigit_t;

  // Scheduler FSM states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // 10**n as a 64-bit constant, evaluated at elaboration time.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin selector. The search begins at ptr
//            and wraps modulo NUM_REQ; the first set request wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int c_idxW = $clog2(NUM_REQ);

  int                w_pos;
  logic [c_idxW-1:0] w_cand;
  logic              w_found;

  // Walk the requesters starting at ptr and pick the first active one.
  always_comb begin
    grant   = '0;
    idx     = '0;
    w_pos   = 0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = int'(ptr) + i;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      w_cand = w_pos[c_idxW-1:0];
      if (!w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        idx           = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_scheduler
// Brief    : Shares one external binary-to-BCD converter between NUM_REQ
//            requesters. Round-robin grant, one conversion in flight, a
//            bounded wait on the converter and a held response slot.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_convert_scheduler
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BIN_W   = 32,
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][BIN_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             conv_load,
  output logic [BIN_W-1:0]                 conv_bin,
  input  logic                             conv_busy,
  input  bcdDigit_t [DIGITS-1:0]           conv_bcd,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output bcdDigit_t [DIGITS-1:0]           rsp_bcd,
  output logic                             rsp_ovf,
  output logic                             rsp_err
);

  localparam int c_idxW = $clog2(NUM_REQ);
  localparam int c_cntW = $clog2(TIMEOUT + 1);
  // Comparison width wide enough for both the operand and 10**DIGITS.
  localparam int c_cmpW = (BIN_W > 64) ? BIN_W : 64;

  localparam logic [c_idxW-1:0] c_lastIdx  = c_idxW'(NUM_REQ - 1);
  localparam logic [c_cntW-1:0] c_cntLast  = c_cntW'(TIMEOUT - 1);
  localparam logic [c_cmpW-1:0] c_ovfLimit = c_cmpW'(pow10(DIGITS));

  state_t                  r_state;
  logic [c_idxW-1:0]       r_ptr;
  logic [c_idxW-1:0]       r_id;
  logic [c_cntW-1:0]       r_cnt;
  logic [BIN_W-1:0]        r_operand;
  logic                    r_ovf;
  logic                    r_err;
  bcdDigit_t [DIGITS-1:0]  r_bcd;

  logic [NUM_REQ-1:0]      w_grant;
  logic [c_idxW-1:0]       w_idx;
  logic [BIN_W-1:0]        w_winData;
  logic                    w_winOvf;
  logic [c_idxW-1:0]       w_ptrNext;
  logic                    w_anyReq;
  logic                    w_idle;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  assign w_anyReq  = |req_valid;
  assign w_idle    = (r_state == IDLE) && !rst;
  assign w_winData = req_data[w_idx];
  assign w_winOvf  = c_cmpW'(w_winData) >= c_ovfLimit;
  assign w_ptrNext = (w_idx == c_lastIdx) ? '0 : w_idx + 1'b1;

  // Handshake strobes are decoded from the state register and forced low in reset.
  assign req_ready = w_idle ? w_grant : '0;
  assign conv_load = (r_state == LOAD) && !rst;
  assign rsp_valid = (r_state == RESP) && !rst;

  assign conv_bin  = r_operand;
  assign rsp_id    = r_id;
  assign rsp_bcd   = r_bcd;
  assign rsp_ovf   = r_ovf;
  assign rsp_err   = r_err;

  // Scheduler FSM: grant, load, settle, wait for the converter, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_operand <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_operand <= w_winData;
            r_id      <= w_idx;
            r_ovf     <= w_winOvf;
            r_ptr     <= w_ptrNext;
            r_cnt     <= '0;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_state <= SETTLE;
        end
        SETTLE: begin
          // Converter busy is not yet meaningful here.
          r_state <= WAIT;
        end
        WAIT: begin
          if (!conv_busy) begin
            r_bcd   <= conv_bcd;
            r_err   <= 1'b0;
            r_state <= RESP;
          end else if (r_cnt == c_cntLast) begin
            // TIMEOUT busy cycles elapsed: report an empty, flagged result.
            r_cnt   <= r_cnt + 1'b1;
            r_bcd   <= '0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_convert_scheduler
// Brief    : Self-checking bench for bcd_convert_scheduler with a behavioural
//            converter and a round-robin / arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_scheduler;

  localparam int NUM_REQ = 4;
  localparam int BIN_W   = 32;
  localparam int DIGITS  = 3;
  localparam int TIMEOUT = 256;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [3:0]             req_valid = '0;
  logic [3:0][31:0]       req_data = '0;
  logic [3:0]             req_ready;
  logic                   conv_load;
  logic [31:0]            conv_bin;
  logic                   conv_busy = 1'b0;
  logic [11:0]            conv_bcd = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [1:0]             rsp_id;
  logic [11:0]            rsp_bcd;
  logic                   rsp_ovf;
  logic                   rsp_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int modelPtr = 0;
  int busyLat = 0;        // busy WAIT cycles for the next load; negative = never finishes
  logic [31:0] cvOp = '0; // operand the converter model saw on conv_bin
  int cvRemain = 0;
  bit cvForever = 1'b0;

  bcd_convert_scheduler #(
    .NUM_REQ (NUM_REQ),
    .BIN_W   (BIN_W),
    .DIGITS  (DIGITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .conv_load (conv_load),
    .conv_bin  (conv_bin),
    .conv_busy (conv_busy),
    .conv_bcd  (conv_bcd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_bcd   (rsp_bcd),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits of v, least significant digit in the low nibble.
  function automatic logic [11:0] toBcd(input logic [31:0] v);
    logic [31:0] t;
    logic [11:0] r;
    t = v;
    r = '0;
    for (int d = 0; d < 3; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Round-robin reference: first set bit scanning upward from p, wrapping.
  function automatic int rrPick(input logic [3:0] m, input int p);
    for (int i = 0; i < 4; i++) begin
      if (m[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // Converter model: busy after load, garbage digits until done, then true digits.
  always @(negedge clk) begin
    if (conv_load) begin
      cvOp      <= conv_bin;
      cvForever <= (busyLat < 0);
      cvRemain  <= busyLat + 2;
      conv_busy <= 1'b1;
      conv_bcd  <= 12'($urandom);
    end else if (!cvForever && cvRemain > 0) begin
      cvRemain <= cvRemain - 1;
      if (cvRemain == 1) begin
        conv_busy <= 1'b0;
        conv_bcd  <= toBcd(cvOp);
      end else begin
        conv_bcd  <= 12'($urandom);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present mask, wait for the grant, drop requests, wait for the response.
  task automatic transact(input logic [3:0] mask, input int lat,
                          output logic [3:0] gnt, output int latency, output bit hung);
    int c0;
    bit seen;
    hung = 1'b0; gnt = '0; latency = -1; seen = 1'b0; c0 = 0;
    busyLat   = lat;
    req_valid = mask;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready !== 4'b0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      hung = 1'b1;
      req_valid = '0;
      return;
    end
    gnt = req_ready;
    c0  = cyc;
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int n = 0; n < TIMEOUT + 40; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) hung = 1'b1;
    else latency = cyc - c0;
  endtask

  // Wait for the in-flight response and let it be consumed.
  task automatic drain();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < TIMEOUT + 40; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drain: rsp_valid got 0 want 1 within bound"); end
    tick();
  endtask

  task automatic test_reset();
    for (int j = 0; j < 4; j++) req_data[j] = 32'($urandom_range(0, 999));
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; busyLat = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (conv_load !== 1'b0) begin errors++; $display("FAIL rst_conv_load: got %b want 0", conv_load); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
    checks++; if ({rsp_id, rsp_bcd, rsp_ovf, rsp_err} !== 16'h0) begin
      errors++; $display("FAIL rst_rsp_fields: got id=%0d bcd=%h ovf=%b err=%b want all 0", rsp_id, rsp_bcd, rsp_ovf, rsp_err); end
    checks++; if (conv_bin !== 32'h0) begin errors++; $display("FAIL rst_conv_bin: got %h want 0", conv_bin); end
    modelPtr = 1;
    tick();
    req_valid = '0;
    drain();
  endtask

  task automatic test_single();
    logic [3:0] g; int lat; bit hung; int w;
    req_data[0] = 32'd123;
    w = rrPick(4'b0001, modelPtr); modelPtr = (w + 1) % 4;
    transact(4'b0001, 0, g, lat, hung);
    checks++; if (hung) begin errors++; $display("FAIL single_done: got timeout want response"); end
    checks++; if (g !== 4'(1 << w)) begin errors++; $display("FAIL single_grant: got %b want %b", g, 4'(1 << w)); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", lat); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_bcd !== 12'h123) begin errors++; $display("FAIL single_bcd: got %h want 123", rsp_bcd); end
    checks++; if (rsp_ovf !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL single_flags: got ovf=%b err=%b want 0 0", rsp_ovf, rsp_err); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] prev; int pending; int grants; int exp;
    rst = 1'b1; req_valid = '0;
    repeat (2) tick();
    rst = 1'b0; modelPtr = 0; busyLat = 0;
    for (int j = 0; j < 4; j++) req_data[j] = 32'($urandom_range(0, 999));
    req_valid = 4'hF;
    prev = '0; pending = 0; grants = 0;
    for (int cy = 0; cy < 26; cy++) begin
      @(negedge clk);
      checks++; if (conv_load !== (prev != 4'b0)) begin
        errors++; $display("FAIL rr_load cycle %0d: got %b want %b", cy, conv_load, (prev != 4'b0)); end
      if (req_ready !== 4'b0) begin
        exp = rrPick(4'hF, modelPtr);
        checks++; if (prev !== 4'b0) begin errors++; $display("FAIL rr_pulse cycle %0d: got two-cycle grant %b want one-cycle", cy, req_ready); end
        checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rr_grant #%0d: got %b want %b", grants, req_ready, 4'(1 << exp)); end
        pending = exp; modelPtr = (exp + 1) % 4; grants++;
      end
      if (rsp_valid === 1'b1) begin
        checks++; if (rsp_id !== 2'(pending)) begin errors++; $display("FAIL rr_id: got %0d want %0d", rsp_id, pending); end
        checks++; if (rsp_bcd !== toBcd(req_data[pending])) begin errors++; $display("FAIL rr_bcd: got %h want %h", rsp_bcd, toBcd(req_data[pending])); end
      end
      prev = req_ready;
    end
    checks++; if (grants !== 6) begin errors++; $display("FAIL rr_count: got %0d grants want 6", grants); end
    tick();
    req_valid = '0;
    drain();
  endtask

  task automatic test_overflow();
    logic [3:0] g; int lat; bit hung; int w;
    logic [31:0] vals [2];
    vals[0] = 32'd1000; vals[1] = 32'd999;
    for (int k = 0; k < 2; k++) begin
      req_data[2] = vals[k];
      w = rrPick(4'b0100, modelPtr); modelPtr = (w + 1) % 4;
      transact(4'b0100, 0, g, lat, hung);
      checks++; if (hung) begin errors++; $display("FAIL ovf_done %0d: got timeout want response", vals[k]); end
      checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_id: got %0d want 2", rsp_id); end
      checks++; if (rsp_ovf !== (vals[k] >= 32'd1000)) begin errors++; $display("FAIL ovf_flag %0d: got %b want %b", vals[k], rsp_ovf, (vals[k] >= 32'd1000)); end
      checks++; if (rsp_bcd !== toBcd(vals[k])) begin errors++; $display("FAIL ovf_bcd %0d: got %h want %h", vals[k], rsp_bcd, toBcd(vals[k])); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL ovf_err: got %b want 0", rsp_err); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] g; int lat; bit hung; int w; logic [3:0] mask; int bl; int sel;
    for (int it = 0; it < 10; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: req_data[j] = 32'($urandom_range(0, 999));
          1: req_data[j] = 32'd999;
          2: req_data[j] = 32'd1000;
          default: req_data[j] = $urandom;
        endcase
      end
      bl = $urandom_range(0, 6);
      w = rrPick(mask, modelPtr); modelPtr = (w + 1) % 4;
      transact(mask, bl, g, lat, hung);
      checks++; if (hung) begin errors++; $display("FAIL rand_done it%0d: got timeout want response", it); end
      checks++; if (g !== 4'(1 << w)) begin errors++; $display("FAIL rand_grant it%0d mask %b: got %b want %b", it, mask, g, 4'(1 << w)); end
      checks++; if (lat !== 4 + bl) begin errors++; $display("FAIL rand_latency it%0d: got %0d want %0d", it, lat, 4 + bl); end
      checks++; if (cvOp !== req_data[w]) begin errors++; $display("FAIL rand_conv_bin it%0d: got %h want %h", it, cvOp, req_data[w]); end
      checks++; if (rsp_id !== 2'(w)) begin errors++; $display("FAIL rand_id it%0d: got %0d want %0d", it, rsp_id, w); end
      checks++; if (rsp_bcd !== toBcd(req_data[w])) begin errors++; $display("FAIL rand_bcd it%0d: got %h want %h", it, rsp_bcd, toBcd(req_data[w])); end
      checks++; if (rsp_ovf !== (req_data[w] >= 32'd1000)) begin errors++; $display("FAIL rand_ovf it%0d: got %b want %b", it, rsp_ovf, (req_data[w] >= 32'd1000)); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rand_err it%0d: got %b want 0", it, rsp_err); end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [3:0] g; int lat; bit hung; int w;
    req_data[3] = 32'd77;
    w = rrPick(4'b1000, modelPtr); modelPtr = (w + 1) % 4;
    transact(4'b1000, -1, g, lat, hung);
    checks++; if (hung) begin errors++; $display("FAIL to_done: got no response want timeout response"); end
    checks++; if (lat < 3 + TIMEOUT || lat > 4 + TIMEOUT) begin
      errors++; $display("FAIL to_latency: got %0d want %0d..%0d", lat, 3 + TIMEOUT, 4 + TIMEOUT); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", rsp_err); end
    checks++; if (rsp_bcd !== 12'h0) begin errors++; $display("FAIL to_bcd: got %h want 000", rsp_bcd); end
    checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL to_id: got %0d want 3", rsp_id); end
    tick();
    req_data[0] = 32'd999;
    w = rrPick(4'b0001, modelPtr); modelPtr = (w + 1) % 4;
    transact(4'b0001, 1, g, lat, hung);
    checks++; if (hung) begin errors++; $display("FAIL to_next_done: got timeout want response"); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL to_next_latency: got %0d want 5", lat); end
    checks++; if (rsp_err !== 1'b0 || rsp_bcd !== 12'h999) begin
      errors++; $display("FAIL to_next_result: got err=%b bcd=%h want 0 999", rsp_err, rsp_bcd); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] g; int lat; bit hung; int w; int w2; logic [15:0] held;
    req_data[1] = 32'd456;
    rsp_ready = 1'b0;
    w = rrPick(4'b0010, modelPtr); modelPtr = (w + 1) % 4;
    transact(4'b0010, 2, g, lat, hung);
    checks++; if (hung) begin errors++; $display("FAIL bp_done: got timeout want response"); end
    checks++; if (lat !== 6 || rsp_id !== 2'd1 || rsp_bcd !== 12'h456) begin
      errors++; $display("FAIL bp_result: got lat=%0d id=%0d bcd=%h want 6 1 456", lat, rsp_id, rsp_bcd); end
    req_data[0] = 32'd321; req_data[2] = 32'd654; req_data[3] = 32'd987;
    req_valid = 4'b1101;
    held = {rsp_id, rsp_bcd, rsp_ovf, rsp_err};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d: got %b want 1", k, rsp_valid); end
      checks++; if ({rsp_id, rsp_bcd, rsp_ovf, rsp_err} !== held) begin
        errors++; $display("FAIL bp_stable cycle %0d: got %h want %h", k, {rsp_id, rsp_bcd, rsp_ovf, rsp_err}, held); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_no_grant cycle %0d: got %b want 0000", k, req_ready); end
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b want 1", rsp_valid); end
    @(negedge clk);
    w2 = rrPick(4'b1101, modelPtr); modelPtr = (w2 + 1) % 4;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'(1 << w2)) begin errors++; $display("FAIL bp_idle_grant: got %b want %b", req_ready, 4'(1 << w2)); end
    tick();
    req_valid = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    bit seen;
    req_data[0] = 32'd1234; req_data[1] = 32'd11; req_data[2] = 32'd22; req_data[3] = 32'd33;
    busyLat = -1; req_valid = 4'b0001; seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready !== 4'b0) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_grant: got no grant want 0001"); end
    tick();
    req_valid = '0;
    repeat (6) tick();
    rst = 1'b1; req_valid = 4'hF; busyLat = 0;
    @(negedge clk);
    checks++; if ({req_ready, conv_load, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL mid_rst_strobes: got ready=%b load=%b valid=%b want 0", req_ready, conv_load, rsp_valid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, conv_load, rsp_id, rsp_bcd, rsp_ovf, rsp_err} !== 18'h0) begin
      errors++; $display("FAIL mid_outputs: got valid=%b load=%b id=%0d bcd=%h ovf=%b err=%b want all 0",
                         rsp_valid, conv_load, rsp_id, rsp_bcd, rsp_ovf, rsp_err); end
    checks++; if (conv_bin !== 32'h0) begin errors++; $display("FAIL mid_conv_bin: got %h want 0", conv_bin); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    modelPtr = 1;
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || rsp_id !== 2'd0 || rsp_bcd !== 12'h234 || rsp_ovf !== 1'b1) begin
      errors++; $display("FAIL mid_after: got seen=%b id=%0d bcd=%h ovf=%b want 1 0 234 1", seen, rsp_id, rsp_bcd, rsp_ovf); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_random();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_convert_scheduler.md
BCD_CONVERT_SCHEDULER -- requirements
Module: bcd_convert_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter BIN_W, default 32, binary operand width.
REQ-003 The block SHALL have parameter DIGITS, default 3, BCD digit count (4 bits per digit).
REQ-004 The block SHALL have parameter TIMEOUT, default 256, maximum WAIT cycles per conversion.
REQ-005 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-008 The block SHALL have port req_data  input  NUM_REQ x BIN_W  per-requester binary operand.
REQ-009 The block SHALL have port req_ready  output  NUM_REQ  one-hot accept pulse.
REQ-010 The block SHALL have port conv_load  output  1  converter load pulse.
REQ-011 The block SHALL have port conv_bin  output  BIN_W  operand presented to converter.
REQ-012 The block SHALL have port conv_busy  input  1  converter still accumulating.
REQ-013 The block SHALL have port conv_bcd  input  DIGITS x 4  converter digit result.
REQ-014 The block SHALL have port rsp_valid  output  1  result available.
REQ-015 The block SHALL have port rsp_ready  input  1  result consumer accepts.
REQ-016 The block SHALL have port rsp_id  output  clog2(NUM_REQ)  index of served requester.
REQ-017 The block SHALL have port rsp_bcd  output  DIGITS x 4  captured result.
REQ-018 The block SHALL have port rsp_ovf  output  1  operand >= 10^DIGITS.
REQ-019 The block SHALL have port rsp_err  output  1  conversion timed out.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, SETTLE, WAIT, RESP; exactly one conversion in flight.
REQ-021 In IDLE with any req_valid set, the block SHALL assert req_ready for the round-robin winner (combinational, same cycle), latch its req_data, index and overflow flag, and go to LOAD.
REQ-022 Round robin: search starts at pointer ptr; on grant, ptr <= winner+1 modulo NUM_REQ.
REQ-023 In IDLE with no req_valid, req_ready SHALL be all-zero and state SHALL hold.
REQ-024 LOAD SHALL last one cycle with conv_load=1 and conv_bin=latched operand; conv_load SHALL be 0 in all other states.
REQ-025 conv_bin SHALL hold the latched operand from LOAD until the next grant.
REQ-026 SETTLE SHALL last exactly one cycle, conv_busy ignored.
REQ-027 In WAIT, when conv_busy=0, the block SHALL capture conv_bcd into rsp_bcd, clear rsp_err, and go to RESP.
REQ-028 In WAIT, the timeout counter SHALL increment each cycle; at count TIMEOUT with conv_busy still 1, rsp_bcd SHALL be 0, rsp_err SHALL be 1, and state SHALL go to RESP.
REQ-029 The timeout counter SHALL be clog2(TIMEOUT+1) bits and clear on entry to LOAD.
REQ-030 rsp_valid SHALL be 1 only in RESP; rsp_id/rsp_bcd/rsp_ovf/rsp_err SHALL be stable while rsp_valid=1.
REQ-031 In RESP, rsp_ready=1 SHALL return the FSM to IDLE; the next grant SHALL occur no earlier than that IDLE cycle.
REQ-032 Minimum latency: accept at cycle T, rsp_valid at T+4 when conv_busy=0 at T+3.
REQ-033 rsp_ovf SHALL be computed as operand >= 10^DIGITS at accept; the conversion SHALL still run and its digits SHALL still be reported.
REQ-034 A requester dropping req_valid before grant SHALL not be served; no request SHALL be lost once req_ready has pulsed.

Reset
REQ-035 On rst=1 at a clock edge, state<=IDLE, ptr<=0, timeout counter<=0, latched operand/id<=0, and rsp_bcd/rsp_ovf/rsp_err<=0, from any state including mid-conversion.
REQ-036 While rst=1, req_ready, conv_load and rsp_valid SHALL all be 0.

Structure
REQ-037 The FSM state enum and the BCD digit typedef (4-bit) SHALL reside in a shared package bcd_pkg.
REQ-038 Round-robin selection SHALL be one sub-module rr_arbiter (inputs: request vector, ptr; output: one-hot grant, encoded index).

Verification
REQ-039 Single request 0 value 123 (DIGITS=3), conv_busy low at T+3 -> rsp_valid at T+4, rsp_id=0, rsp_bcd=1,2,3, rsp_ovf=0.
REQ-040 All four req_valid held high -> grants in order 0,1,2,3,0; each req_ready is a one-cycle pulse.
REQ-041 Operand 1000 on requester 2 -> rsp_ovf=1, rsp_id=2, rsp_bcd equals the conv_bcd value sampled.
REQ-042 conv_busy held at 1 -> rsp_err=1 and rsp_bcd=0 after 256 WAIT cycles; the next request then completes normally.
REQ-043 rsp_ready held at 0 for 10 cycles -> rsp outputs remain stable and no req_ready pulse occurs; release -> IDLE on the next cycle.
REQ-044 rst asserted during WAIT -> next cycle IDLE, all outputs 0, ptr=0; requester 0 is granted first afterwards.
